// File: rtl/f11_svc_pkg.sv
// Shared constants for the F11 service word: svc bit positions, reset image
// and the packed layout of the synchronized level-input group.
package f11_svc_pkg;

  localparam int unsigned SVC_EVNT = 12;
  localparam int unsigned SVC_IRQ4 = 11;
  localparam int unsigned SVC_IRQ5 = 10;
  localparam int unsigned SVC_IRQ6 = 9;
  localparam int unsigned SVC_IRQ7 = 8;
  localparam int unsigned SVC_ACLO = 7;
  localparam int unsigned SVC_HALT = 5;
  localparam int unsigned SVC_CCE  = 4;
  localparam int unsigned SVC_MMU  = 3;
  localparam int unsigned SVC_PAR  = 2;
  localparam int unsigned SVC_TMO  = 1;
  localparam int unsigned SVC_DCLO = 0;

  localparam logic [15:0] SVC_RESET = 16'h009C;

  typedef struct packed {
    logic [3:0] irq;     // irq[0] = IRQ4 ... irq[3] = IRQ7
    logic       aclo_n;
    logic       dclo_n;
    logic       halt;
    logic       mmu_n;
    logic       par_n;
  } lvl_t;

  localparam int unsigned LVL_W = $bits(lvl_t);

  localparam lvl_t LVL_RESET = '{irq: 4'b0000, aclo_n: 1'b1, dclo_n: 1'b0,
                                 halt: 1'b0, mmu_n: 1'b1, par_n: 1'b1};

endpackage

// File: rtl/f11_svc_if.sv
// Board-side signal bundle of the service-word block; slave is the block,
// master is whatever drives the board conditions and reads the word.
interface f11_svc_if;

  logic [3:0]  pin_irq;
  logic        pin_evnt;
  logic        pin_aclo_n;
  logic        pin_dclo_n;
  logic        pin_halt;
  logic        pin_mmu_n;
  logic        pin_par_n;
  logic        pin_rply;
  logic        bus_sync;
  logic        evnt_ack;
  logic        tmo_clr;
  logic        pin_cs_n;
  logic        rd_svc;
  logic [15:0] svc;
  logic        ad_oe;

  modport slave (
    input  pin_irq, pin_evnt, pin_aclo_n, pin_dclo_n, pin_halt, pin_mmu_n,
           pin_par_n, pin_rply, bus_sync, evnt_ack, tmo_clr, pin_cs_n, rd_svc,
    output svc, ad_oe
  );

  modport master (
    output pin_irq, pin_evnt, pin_aclo_n, pin_dclo_n, pin_halt, pin_mmu_n,
           pin_par_n, pin_rply, bus_sync, evnt_ack, tmo_clr, pin_cs_n, rd_svc,
    input  svc, ad_oe
  );

endinterface

// File: rtl/f11_sync.sv
// Multi-bit async-input synchronizer; each bit resets to its own inactive level.
module f11_sync #(
  parameter int unsigned            WIDTH   = 1,
  parameter int unsigned            STAGES  = 2,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/f11_svc_word.sv
// F11 external service word: synchronized board conditions, latched event,
// bus timeout and control-chip-error flags, all from registered state.
module f11_svc_word
  import f11_svc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TMO_CYCLES  = 64,
  parameter int unsigned CCE_CYCLES  = 4
) (
  input  logic        pin_clk,
  input  logic        pin_rst_n,
  f11_svc_if.slave    bus
);

  localparam int unsigned TW = $clog2(TMO_CYCLES) + 1;
  localparam int unsigned CW = $clog2(CCE_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TMO_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam logic [CW-1:0] CCE_MAX  = CW'(CCE_CYCLES);
  localparam logic [CW-1:0] CCE_LAST = CW'(CCE_CYCLES - 1);

  lvl_t       lvl_in;
  lvl_t       lvl_s;
  logic [1:0] evrp_s;
  logic       evnt_s;
  logic       rply_s;

  assign lvl_in = {bus.pin_irq, bus.pin_aclo_n, bus.pin_dclo_n, bus.pin_halt,
                   bus.pin_mmu_n, bus.pin_par_n};

  f11_sync #(.WIDTH(LVL_W), .STAGES(SYNC_STAGES), .RST_VAL(LVL_RESET)) u_lvl_sync (
    .clk   (pin_clk),
    .rst_n (pin_rst_n),
    .din   (lvl_in),
    .dout  (lvl_s)
  );

  f11_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b00)) u_bus_sync (
    .clk   (pin_clk),
    .rst_n (pin_rst_n),
    .din   ({bus.pin_evnt, bus.pin_rply}),
    .dout  (evrp_s)
  );

  assign evnt_s = evrp_s[1];
  assign rply_s = evrp_s[0];

  logic          evnt_prev_q, evnt_prev_d;
  logic          evnt_q, evnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          cce_n_q, cce_n_d;

  // Each flag is set from a single counter/edge transition, and a set in the
  // same cycle as its clear takes priority.
  always_comb begin
    evnt_prev_d = evnt_s;
    evnt_d      = (evnt_s & ~evnt_prev_q) | (evnt_q & ~bus.evnt_ack);

    tcnt_d = '0;
    tmo_d  = tmo_q & ~bus.tmo_clr;
    if (bus.bus_sync && !rply_s) begin
      tcnt_d = (tcnt_q == TMO_MAX) ? tcnt_q : tcnt_q + TW'(1);
      if (tcnt_q == TMO_LAST) begin
        tmo_d = 1'b1;
      end
    end

    ccnt_d  = '0;
    cce_n_d = cce_n_q;
    if (bus.pin_cs_n) begin
      ccnt_d = (ccnt_q == CCE_MAX) ? ccnt_q : ccnt_q + CW'(1);
      if (ccnt_q == CCE_LAST) begin
        cce_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      evnt_prev_q <= 1'b0;
      evnt_q      <= 1'b0;
      tcnt_q      <= '0;
      tmo_q       <= 1'b0;
      ccnt_q      <= '0;
      cce_n_q     <= 1'b1;
    end else begin
      evnt_prev_q <= evnt_prev_d;
      evnt_q      <= evnt_d;
      tcnt_q      <= tcnt_d;
      tmo_q       <= tmo_d;
      ccnt_q      <= ccnt_d;
      cce_n_q     <= cce_n_d;
    end
  end

  logic [15:0] svc_w;

  always_comb begin
    svc_w           = '0;
    svc_w[SVC_EVNT] = evnt_q;
    svc_w[SVC_IRQ4] = lvl_s.irq[0];
    svc_w[SVC_IRQ5] = lvl_s.irq[1];
    svc_w[SVC_IRQ6] = lvl_s.irq[2];
    svc_w[SVC_IRQ7] = lvl_s.irq[3];
    svc_w[SVC_ACLO] = lvl_s.aclo_n;
    svc_w[SVC_HALT] = lvl_s.halt;
    svc_w[SVC_CCE]  = cce_n_q;
    svc_w[SVC_MMU]  = lvl_s.mmu_n;
    svc_w[SVC_PAR]  = lvl_s.par_n;
    svc_w[SVC_TMO]  = tmo_q;
    svc_w[SVC_DCLO] = lvl_s.dclo_n;
  end

  assign bus.svc   = svc_w;
  assign bus.ad_oe = bus.rd_svc & pin_rst_n;

endmodule

// File: tb/tb_f11_svc_word.sv
// Directed bench for f11_svc_word with a cycle-history reference model of the
// service word compared every cycle, plus literal spot checks.
module tb_f11_svc_word;

  localparam int S   = 2;
  localparam int TMO = 64;
  localparam int CCE = 4;
  localparam logic [15:0] LEVEL_MASK = 16'h0FAD;

  logic pin_clk   = 1'b0;
  logic pin_rst_n = 1'b0;

  f11_svc_if bus ();

  f11_svc_word #(.SYNC_STAGES(S), .TMO_CYCLES(TMO), .CCE_CYCLES(CCE)) dut (
    .pin_clk   (pin_clk),
    .pin_rst_n (pin_rst_n),
    .bus       (bus)
  );

  initial forever #5 pin_clk = ~pin_clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw input samples per edge (index 0 = newest edge).
  logic [15:0] lvl_h [0:S+1];
  logic        e_h   [0:S+1];
  logic        r_h   [0:S+1];
  logic        m_evnt, m_tmo, m_cce_n;
  int          tmo_run, cs_run;

  function automatic logic [15:0] raw_word();
    logic [15:0] w;
    w     = '0;
    w[11] = bus.pin_irq[0];
    w[10] = bus.pin_irq[1];
    w[9]  = bus.pin_irq[2];
    w[8]  = bus.pin_irq[3];
    w[7]  = bus.pin_aclo_n;
    w[5]  = bus.pin_halt;
    w[3]  = bus.pin_mmu_n;
    w[2]  = bus.pin_par_n;
    w[0]  = bus.pin_dclo_n;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= S + 1; i++) begin
      lvl_h[i] = 16'h008C;
      e_h[i]   = 1'b0;
      r_h[i]   = 1'b0;
    end
    m_evnt = 1'b0; m_tmo = 1'b0; m_cce_n = 1'b1;
    tmo_run = 0; cs_run = 0;
  endtask

  task automatic model_step();
    for (int i = S + 1; i > 0; i--) begin
      lvl_h[i] = lvl_h[i-1];
      e_h[i]   = e_h[i-1];
      r_h[i]   = r_h[i-1];
    end
    lvl_h[0] = raw_word();
    e_h[0]   = bus.pin_evnt;
    r_h[0]   = bus.pin_rply;
    m_evnt = (e_h[S] & ~e_h[S+1]) | (m_evnt & ~bus.evnt_ack);
    tmo_run = (bus.bus_sync && !r_h[S]) ? tmo_run + 1 : 0;
    m_tmo = (tmo_run == TMO) | (m_tmo & ~bus.tmo_clr);
    cs_run = bus.pin_cs_n ? cs_run + 1 : 0;
    if (cs_run == CCE) m_cce_n = 1'b0;
  endtask

  function automatic logic [15:0] model_svc();
    return (lvl_h[S-1] & LEVEL_MASK) | (16'(m_evnt) << 12) |
           (16'(m_cce_n) << 4) | (16'(m_tmo) << 1);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge pin_clk or negedge pin_rst_n);
      if (!pin_rst_n) model_reset();
      else            model_step();
    end
  end

  initial begin
    @(posedge pin_clk);
    forever begin
      @(posedge pin_clk);
      #6;
      check("svc_model", bus.svc, pin_rst_n ? model_svc() : 16'h009C);
      check("ad_oe_model", {15'b0, bus.ad_oe}, {15'b0, bus.rd_svc & pin_rst_n});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pin_clk);
    #2;
  endtask

  task automatic inactive();
    bus.pin_irq = 4'h0; bus.pin_evnt = 1'b0; bus.pin_aclo_n = 1'b1;
    bus.pin_dclo_n = 1'b0; bus.pin_halt = 1'b0; bus.pin_mmu_n = 1'b1;
    bus.pin_par_n = 1'b1; bus.pin_rply = 1'b0; bus.bus_sync = 1'b0;
    bus.evnt_ack = 1'b0; bus.tmo_clr = 1'b0; bus.pin_cs_n = 1'b0;
    bus.rd_svc = 1'b0;
  endtask

  initial begin
    inactive();
    // Reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      bus.pin_irq = 4'($urandom); bus.pin_evnt = 1'($urandom);
      bus.pin_aclo_n = 1'($urandom); bus.pin_dclo_n = 1'($urandom);
      bus.pin_halt = 1'($urandom); bus.pin_mmu_n = 1'($urandom);
      bus.pin_par_n = 1'($urandom); bus.pin_rply = 1'($urandom);
      bus.bus_sync = 1'($urandom); bus.pin_cs_n = 1'($urandom);
      bus.rd_svc = 1'($urandom);
      tick(1);
      check("rst_svc", bus.svc, 16'h009C);
      check("rst_ad_oe", {15'b0, bus.ad_oe}, 16'h0000);
    end
    inactive();
    tick(1);
    pin_rst_n = 1'b1;
    tick(4);
    check("post_rst_svc", bus.svc, 16'h009C);

    // IRQ latency
    bus.rd_svc = 1'b1;
    bus.pin_irq = 4'b0001;
    tick(1);
    check("irq4_edge1", {15'b0, bus.svc[11]}, 16'h0000);
    tick(1);
    check("irq4_edge2", {15'b0, bus.svc[11]}, 16'h0001);
    check("ad_oe_rd", {15'b0, bus.ad_oe}, 16'h0001);
    bus.pin_irq = 4'b1010; bus.pin_halt = 1'b1; bus.pin_aclo_n = 1'b0;
    bus.pin_par_n = 1'b0; bus.pin_mmu_n = 1'b0; bus.pin_dclo_n = 1'b1;
    tick(2);
    check("level_pattern", bus.svc, 16'h0531);
    inactive();
    tick(3);
    check("level_restore", bus.svc, 16'h009C);

    // Event request
    bus.pin_evnt = 1'b1;
    tick(2);
    check("evnt_edge2", {15'b0, bus.svc[12]}, 16'h0000);
    tick(1);
    check("evnt_edge3", {15'b0, bus.svc[12]}, 16'h0001);
    bus.evnt_ack = 1'b1; tick(1); bus.evnt_ack = 1'b0;
    check("evnt_ack", {15'b0, bus.svc[12]}, 16'h0000);
    tick(3);
    check("evnt_held", {15'b0, bus.svc[12]}, 16'h0000);
    bus.pin_evnt = 1'b0; tick(3);
    bus.pin_evnt = 1'b1; tick(2);
    bus.evnt_ack = 1'b1; tick(1); bus.evnt_ack = 1'b0;
    check("evnt_set_wins", {15'b0, bus.svc[12]}, 16'h0001);
    bus.evnt_ack = 1'b1; tick(1); bus.evnt_ack = 1'b0;
    bus.pin_evnt = 1'b0; tick(3);

    // Bus timeout
    bus.bus_sync = 1'b1;
    tick(63);
    check("tmo_edge63", {15'b0, bus.svc[1]}, 16'h0000);
    tick(1);
    check("tmo_edge64", {15'b0, bus.svc[1]}, 16'h0001);
    tick(10);
    check("tmo_saturated", {15'b0, bus.svc[1]}, 16'h0001);
    bus.bus_sync = 1'b0; bus.tmo_clr = 1'b1; tick(1); bus.tmo_clr = 1'b0;
    check("tmo_clr", {15'b0, bus.svc[1]}, 16'h0000);
    bus.bus_sync = 1'b1; tick(63);
    bus.tmo_clr = 1'b1; tick(1); bus.tmo_clr = 1'b0;
    check("tmo_set_wins", {15'b0, bus.svc[1]}, 16'h0001);
    bus.bus_sync = 1'b0; bus.tmo_clr = 1'b1; tick(1); bus.tmo_clr = 1'b0;
    bus.bus_sync = 1'b1; tick(39);
    bus.pin_rply = 1'b1; tick(30);
    check("tmo_rply", {15'b0, bus.svc[1]}, 16'h0000);
    bus.bus_sync = 1'b0; tick(1);
    bus.pin_rply = 1'b0; tick(3);

    // Reset mid-count
    bus.bus_sync = 1'b1; tick(50);
    pin_rst_n = 1'b0; tick(1);
    check("midrst_svc", bus.svc, 16'h009C);
    pin_rst_n = 1'b1;
    tick(63);
    check("midrst_tmo63", {15'b0, bus.svc[1]}, 16'h0000);
    tick(1);
    check("midrst_tmo64", {15'b0, bus.svc[1]}, 16'h0001);
    bus.bus_sync = 1'b0; bus.tmo_clr = 1'b1; tick(1); bus.tmo_clr = 1'b0;

    // Control chip error
    bus.pin_cs_n = 1'b1; tick(3);
    bus.pin_cs_n = 1'b0; tick(2);
    check("cce_3cyc", {15'b0, bus.svc[4]}, 16'h0001);
    bus.pin_cs_n = 1'b1; tick(3);
    check("cce_edge3", {15'b0, bus.svc[4]}, 16'h0001);
    tick(1);
    check("cce_edge4", {15'b0, bus.svc[4]}, 16'h0000);
    bus.pin_cs_n = 1'b0; tick(5);
    check("cce_sticky", {15'b0, bus.svc[4]}, 16'h0000);
    pin_rst_n = 1'b0; tick(1);
    check("cce_rst", bus.svc, 16'h009C);
    pin_rst_n = 1'b1; tick(3);
    check("final_svc", bus.svc, 16'h009C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/f11_svc_word.md
Name: f11_svc_word

Overview:
- Builds the external service word that the F11 CPU board places on AD[15:0] for the control chips.
- The control chip samples this word during service-word reads and at read-next-instruction.
- The block synchronizes the asynchronous board conditions (IRQs, line clock, power, halt, MMU, parity) and generates bus timeout and control-chip-error detection.
- It presents one registered, glitch-free 16-bit word, plus an AD drive enable.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of every async input synchronizer (minimum 2).
- TMO_CYCLES, 64, pin_clk cycles of SYNC without RPLY before bus timeout is flagged (minimum 2).
- CCE_CYCLES, 4, consecutive cycles with no chip select before control chip error is flagged (minimum 1).

Ports:
- pin_clk  in  1  main clock, all state on rising edge
- pin_rst_n  in  1  asynchronous active-low reset
- pin_irq  in  4  raw IRQ[7:4], active high, async
- pin_evnt  in  1  raw line-clock event, active high, async
- pin_aclo_n  in  1  raw ACLO, active low, async
- pin_dclo_n  in  1  raw DCLO, low = OK, async
- pin_halt  in  1  raw HALT request, active high, async
- pin_mmu_n  in  1  MMU abort request, active low, async
- pin_par_n  in  1  parity error, active low, async
- pin_rply  in  1  bus reply, active high, async
- bus_sync  in  1  synchronous: bus cycle in progress
- evnt_ack  in  1  synchronous one-cycle pulse: clears the event request
- tmo_clr  in  1  synchronous one-cycle pulse: clears the timeout flag
- pin_cs_n  in  1  wired chip-select from control chips, sampled synchronously
- rd_svc  in  1  synchronous: service word read cycle
- svc  out  16  service word
- ad_oe  out  1  AD drive enable

Behaviour:
- Bit map of svc:
  - [15:13] = 0 (internal bits, supplied by the control chip)
  - [12] evnt request
  - [11] irq4, [10] irq5, [9] irq6, [8] irq7
  - [7] aclo_n, [6] = 0 (ground)
  - [5] halt, [4] cce_n, [3] mmu_n, [2] par_n
  - [1] tmo, [0] dclo_n
- svc is a pure concatenation of registered state bits. No combinational path exists from pin inputs to svc.
- ad_oe = rd_svc & pin_rst_n, combinational.
- Reset (pin_rst_n low): all synchronizer stages and flags go to their inactive levels, and counters go to 0. svc = 16'h009C (aclo_n=1, cce_n=1, mmu_n=1, par_n=1, all others 0). Reset asserted mid-count or mid-request aborts immediately.
- Level bits (irq, aclo_n, dclo_n, halt, mmu_n, par_n):
  - Each passes through a SYNC_STAGES synchronizer; the final stage is the svc bit.
  - A stable change appears on svc after exactly SYNC_STAGES rising edges.
  - Pulses shorter than one clock may be lost; this is permitted.
- Event request:
  - An edge register holds the previous synchronized evnt.
  - A rising edge of synchronized evnt (sync=1, prev=0) sets svc[12] on the next edge: SYNC_STAGES+1 edges after the input rises.
  - svc[12] stays set until an evnt_ack edge clears it.
  - If set and evnt_ack occur in the same cycle, set wins.
  - A held-high evnt does not re-set the request after ack; a new rising edge is required.
- Bus timeout:
  - tcnt has width clog2(TMO_CYCLES)+1 and saturates.
  - tcnt clears when bus_sync=0 or synchronized rply=1; otherwise it increments.
  - When tcnt reaches TMO_CYCLES-1 and increments, svc[1] sets. Timeout is therefore flagged on the TMO_CYCLES-th edge of unreplied SYNC.
  - svc[1] holds until a tmo_clr edge clears it; set wins over a simultaneous clear.
  - tcnt keeps saturating while SYNC stays unreplied, and sets no further flags once saturated.
- Control chip error:
  - ccnt counts consecutive rising edges with pin_cs_n=1 (undriven pulls high) and clears on any edge with pin_cs_n=0.
  - Reaching CCE_CYCLES latches svc[4]=0.
  - svc[4] stays 0 until reset only; it is not software-clearable.
- All edge-sensitive events (evnt edge, tmo set, cce set) are single-cycle decisions; no event is double-counted.

Decomposition:
- Package f11_svc_pkg holds:
  - the bit index constants SVC_EVNT=12, SVC_IRQ4..7, SVC_ACLO, SVC_HALT, SVC_CCE, SVC_MMU, SVC_PAR, SVC_TMO, SVC_DCLO
  - SVC_RESET=16'h009C
- One sub-module, f11_sync, is natural: a parameterized width/stages async-reset synchronizer with a per-bit reset value. It is instantiated once for the 9-bit level group and once for {evnt, rply}.

Test Plan:
- Reset: hold pin_rst_n low, toggle all inputs -> svc=16'h009C and ad_oe=0 throughout; release -> svc=16'h009C while inputs are inactive.
- IRQ latency: assert pin_irq[0] async between edges -> svc[11]=1 exactly after 2 rising edges; with rd_svc=1, ad_oe=1.
- Event with simultaneous ack: raise pin_evnt -> svc[12]=1 on edge 3. Pulse evnt_ack while evnt is held -> svc[12]=0 and stays 0. Drop evnt, re-raise it, and pulse evnt_ack in the set cycle -> svc[12]=1.
- Timeout: bus_sync=1 with no rply -> svc[1]=1 on edge 64, not on edge 63. Repeat with rply at cycle 40 -> svc[1] stays 0. Pulse tmo_clr -> svc[1]=0.
- CCE: pin_cs_n=1 for 3 cycles then 0 -> svc[4] stays 1. Hold high for 4 cycles -> svc[4]=0 and stays 0 after cs_n returns low, until reset.
- Reset mid-count: at tcnt=50, pulse pin_rst_n low -> tcnt=0. Resume SYNC -> timeout flagged 64 edges after release.
